// File: rtl/mips_pkg.sv
// Shared definitions for the pipeline hazard controller: forward-select codes,
// stage indices and the per-stage control tracking record.
package mips_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;
  localparam int N_STG   = 3;

  typedef struct packed {
    logic valid;
    logic use_rs;
    logic use_rt;
    logic regwrite;
    logic memread;
  } stage_ctl_t;

  localparam stage_ctl_t STAGE_BUBBLE = '0;

  typedef enum logic [1:0] {
    CTL_IDLE,
    CTL_FREEZE,
    CTL_FLUSH,
    CTL_STALL
  } ctl_mode_t;

endpackage

// File: rtl/pipe_hazard_ctl_if.sv
// Decode-side bundle of the hazard controller: decode fields and pipeline
// events in, enables/flushes/forward selects/WB tracking out.
interface pipe_hazard_ctl_if #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
);
  logic            id_valid;
  logic [RA_W-1:0] id_rs;
  logic [RA_W-1:0] id_rt;
  logic            id_use_rs;
  logic            id_use_rt;
  logic [RA_W-1:0] id_wrreg;
  logic            id_regwrite;
  logic            id_memread;
  logic            ex_br_taken;
  logic            ext_stall;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             wb_valid;
  logic             wb_regwrite;
  logic [RA_W-1:0]  wb_wrreg;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wrreg,
           id_regwrite, id_memread, ex_br_taken, ext_stall,
    input  pc_en, ifid_en, ifid_flush, idex_flush, fwd_a, fwd_b,
           wb_valid, wb_regwrite, wb_wrreg, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wrreg,
           id_regwrite, id_memread, ex_br_taken, ext_stall,
    output pc_en, ifid_en, ifid_flush, idex_flush, fwd_a, fwd_b,
           wb_valid, wb_regwrite, wb_wrreg, stall_cnt
  );
endinterface

// File: rtl/pipe_fwd_unit.sv
// Operand forward select for one EX source: MEM-stage producer wins over WB,
// register 0 never forwards.
module pipe_fwd_unit
  import mips_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic            src_valid,
  input  logic            src_use,
  input  logic [RA_W-1:0] src_reg,
  input  logic            mem_valid,
  input  logic            mem_regwrite,
  input  logic [RA_W-1:0] mem_wrreg,
  input  logic            wb_valid,
  input  logic            wb_regwrite,
  input  logic [RA_W-1:0] wb_wrreg,
  output logic [1:0]      sel
);

  logic src_live;
  logic mem_hit;
  logic wb_hit;

  assign src_live = src_valid && src_use && (src_reg != '0);
  assign mem_hit  = src_live && mem_valid && mem_regwrite && (mem_wrreg == src_reg);
  assign wb_hit   = src_live && wb_valid && wb_regwrite && (wb_wrreg == src_reg);

  always_comb begin
    sel = FWD_RF;
    if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Pipeline hazard controller: stage tracking, load-use/RAW stalls, branch
// flush, external freeze and stall counting. PIPE_HAZARD_CTL_FWD_EN enables
// operand forwarding; without it every EX/MEM producer hazard stalls decode.
module pipe_hazard_ctl
  import mips_pkg::*;
#(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctl_if.slave bus
);

  stage_ctl_t [N_STG-1:0]           ctl_reg;
  logic       [N_STG-1:0][RA_W-1:0] rs_reg;
  logic       [N_STG-1:0][RA_W-1:0] rt_reg;
  logic       [N_STG-1:0][RA_W-1:0] wr_reg;
  logic       [CNT_W-1:0]           stall_cnt_reg;

  stage_ctl_t id_ctl;
  logic       id_rs_live;
  logic       id_rt_live;
  logic [1:0] raw_hit;
  logic       load_use;
  logic       data_hazard;
  ctl_mode_t  mode;
  logic       front_hold;
  logic       ex_bubble;

  assign id_ctl = '{valid:    bus.id_valid,
                    use_rs:   bus.id_use_rs,
                    use_rt:   bus.id_use_rt,
                    regwrite: bus.id_regwrite,
                    memread:  bus.id_memread};

  assign id_rs_live = bus.id_valid && bus.id_use_rs && (bus.id_rs != '0);
  assign id_rt_live = bus.id_valid && bus.id_use_rt && (bus.id_rt != '0);

  // Producer in EX (gi=0) or MEM (gi=1) writing a register decode reads.
  for (genvar gi = 0; gi < 2; gi++) begin : g_raw
    assign raw_hit[gi] = ctl_reg[gi].valid && ctl_reg[gi].regwrite && (wr_reg[gi] != '0) &&
                         ((id_rs_live && (bus.id_rs == wr_reg[gi])) ||
                          (id_rt_live && (bus.id_rt == wr_reg[gi])));
  end

  assign load_use = raw_hit[STG_EX] && ctl_reg[STG_EX].memread;

`ifdef PIPE_HAZARD_CTL_FWD_EN
  assign data_hazard = load_use;

  pipe_fwd_unit #(.RA_W(RA_W)) u_fwd_a (
    .src_valid    (ctl_reg[STG_EX].valid),
    .src_use      (ctl_reg[STG_EX].use_rs),
    .src_reg      (rs_reg[STG_EX]),
    .mem_valid    (ctl_reg[STG_MEM].valid),
    .mem_regwrite (ctl_reg[STG_MEM].regwrite),
    .mem_wrreg    (wr_reg[STG_MEM]),
    .wb_valid     (ctl_reg[STG_WB].valid),
    .wb_regwrite  (ctl_reg[STG_WB].regwrite),
    .wb_wrreg     (wr_reg[STG_WB]),
    .sel          (bus.fwd_a)
  );

  pipe_fwd_unit #(.RA_W(RA_W)) u_fwd_b (
    .src_valid    (ctl_reg[STG_EX].valid),
    .src_use      (ctl_reg[STG_EX].use_rt),
    .src_reg      (rt_reg[STG_EX]),
    .mem_valid    (ctl_reg[STG_MEM].valid),
    .mem_regwrite (ctl_reg[STG_MEM].regwrite),
    .mem_wrreg    (wr_reg[STG_MEM]),
    .wb_valid     (ctl_reg[STG_WB].valid),
    .wb_regwrite  (ctl_reg[STG_WB].regwrite),
    .wb_wrreg     (wr_reg[STG_WB]),
    .sel          (bus.fwd_b)
  );
`else
  // WB-stage producers are covered by the register file writing before read.
  assign data_hazard = |raw_hit;
  assign bus.fwd_a   = FWD_RF;
  assign bus.fwd_b   = FWD_RF;
`endif

  always_comb begin
    mode = CTL_IDLE;
    if (rst) begin
      mode = CTL_IDLE;
    end else if (bus.ext_stall) begin
      mode = CTL_FREEZE;
    end else if (bus.ex_br_taken) begin
      mode = CTL_FLUSH;
    end else if (data_hazard) begin
      mode = CTL_STALL;
    end
  end

  assign front_hold = (mode == CTL_FREEZE) || (mode == CTL_STALL);
  assign ex_bubble  = (mode == CTL_FLUSH) || (mode == CTL_STALL);

  assign bus.pc_en       = !front_hold;
  assign bus.ifid_en     = !front_hold;
  assign bus.ifid_flush  = (mode == CTL_FLUSH);
  assign bus.idex_flush  = ex_bubble;
  assign bus.wb_valid    = ctl_reg[STG_WB].valid;
  assign bus.wb_regwrite = ctl_reg[STG_WB].regwrite;
  assign bus.wb_wrreg    = wr_reg[STG_WB];
  assign bus.stall_cnt   = stall_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_reg       <= '0;
      rs_reg        <= '0;
      rt_reg        <= '0;
      wr_reg        <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (mode != CTL_FREEZE) begin
        if (ex_bubble) begin
          ctl_reg[STG_EX] <= STAGE_BUBBLE;
          rs_reg[STG_EX]  <= '0;
          rt_reg[STG_EX]  <= '0;
          wr_reg[STG_EX]  <= '0;
        end else begin
          ctl_reg[STG_EX] <= id_ctl;
          rs_reg[STG_EX]  <= bus.id_rs;
          rt_reg[STG_EX]  <= bus.id_rt;
          wr_reg[STG_EX]  <= bus.id_wrreg;
        end
        for (int i = 1; i < N_STG; i++) begin
          ctl_reg[i] <= ctl_reg[i-1];
          rs_reg[i]  <= rs_reg[i-1];
          rt_reg[i]  <= rt_reg[i-1];
          wr_reg[i]  <= wr_reg[i-1];
        end
      end
      if (front_hold && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
    end
  end

  // Later-stage sources and load flags are tracked but feed no decision here.
  logic unused_track;
  assign unused_track = ^{rs_reg, rt_reg, ctl_reg};

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Self-checking bench for pipe_hazard_ctl; follows PIPE_HAZARD_CTL_FWD_EN for
// the expected forwarding/stall behaviour. Reference is an instruction-level model.
module tb_pipe_hazard_ctl;
  import mips_pkg::*;

  localparam int RA_W    = 5;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef PIPE_HAZARD_CTL_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctl_if #(.RA_W(RA_W), .CNT_W(CNT_W)) bus ();
  pipe_hazard_ctl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    bit       v;
    bit [4:0] rs;
    bit [4:0] rt;
    bit       urs;
    bit       urt;
    bit [4:0] wr;
    bit       rw;
    bit       mr;
  } ins_t;

  ins_t        stg [3];   // 0 = EX, 1 = MEM, 2 = WB
  ins_t        cur;
  bit          br, xs;
  int unsigned scnt;
  int          n_cmp = 0;
  int          n_fail = 0;

  bit       e_pc, e_ifid, e_iff, e_idf, e_wbv, e_wbr;
  bit [1:0] e_fa, e_fb;
  bit [4:0] e_wbw;

  wire  [18:0] dut_vec = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_flush,
                          bus.fwd_a, bus.fwd_b, bus.wb_valid, bus.wb_regwrite,
                          bus.wb_wrreg, bus.stall_cnt};
  logic [18:0] exp_vec;

  function automatic ins_t mk(bit v, int rs, bit urs, int rt, bit urt, int wr, bit rw, bit mr);
    ins_t m;
    m.v = v; m.rs = 5'(rs); m.urs = urs; m.rt = 5'(rt); m.urt = urt;
    m.wr = 5'(wr); m.rw = rw; m.mr = mr;
    return m;
  endfunction

  function automatic bit reads(ins_t i, bit [4:0] r);
    return i.v && (r != 0) && ((i.urs && i.rs == r) || (i.urt && i.rt == r));
  endfunction

  function automatic bit produces(ins_t p, bit [4:0] r);
    return p.v && p.rw && (p.wr != 0) && (p.wr == r);
  endfunction

  function automatic bit [1:0] fwd_for(bit use_src, bit [4:0] r);
    if (!FWD_ON || !stg[0].v || !use_src || r == 0) return 2'b00;
    if (produces(stg[1], r)) return 2'b01;
    if (produces(stg[2], r)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) stg[k] = '0;
    scnt = 0;
  endtask

  task automatic model_eval();
    bit haz;
    int last;
    haz  = 1'b0;
    last = FWD_ON ? 0 : 1;
    for (int k = 0; k <= last; k++)
      if (stg[k].v && stg[k].rw && reads(cur, stg[k].wr) && (!FWD_ON || stg[k].mr)) haz = 1'b1;
    {e_pc, e_ifid, e_iff, e_idf} = 4'b1100;
    if (!rst) begin
      if (xs)       {e_pc, e_ifid, e_iff, e_idf} = 4'b0000;
      else if (br)  {e_pc, e_ifid, e_iff, e_idf} = 4'b1111;
      else if (haz) {e_pc, e_ifid, e_iff, e_idf} = 4'b0001;
    end
    e_fa  = fwd_for(stg[0].urs, stg[0].rs);
    e_fb  = fwd_for(stg[0].urt, stg[0].rt);
    e_wbv = stg[2].v;
    e_wbr = stg[2].rw;
    e_wbw = stg[2].wr;
    exp_vec = {e_pc, e_ifid, e_iff, e_idf, e_fa, e_fb, e_wbv, e_wbr, e_wbw, CNT_W'(scnt)};
  endtask

  task automatic drive(ins_t i, bit b, bit x, bit r);
    @(negedge clk);
    cur = i; br = b; xs = x; rst = r;
    bus.id_valid = i.v; bus.id_rs = i.rs; bus.id_rt = i.rt;
    bus.id_use_rs = i.urs; bus.id_use_rt = i.urt; bus.id_wrreg = i.wr;
    bus.id_regwrite = i.rw; bus.id_memread = i.mr;
    bus.ex_br_taken = b; bus.ext_stall = x;
    if (r) model_reset();
    #1;
    model_eval();
    $display("cyc t=%0t v=%0b rs=%0d rt=%0d wr=%0d rw=%0b mr=%0b br=%0b xs=%0b rst=%0b -> %h",
             $time, i.v, i.rs, i.rt, i.wr, i.rw, i.mr, b, x, r, dut_vec);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (!xs) begin
        stg[2] = stg[1];
        stg[1] = stg[0];
        stg[0] = e_idf ? '0 : cur;
      end
      if (!e_pc && scnt < CNT_MAX) scnt++;
    end
  endtask

  ins_t NOP, ADD3, ADD433, LW5, ADD65, W0, U0;

  task automatic test_reset();
    drive(NOP, 1'b0, 1'b1, 1'b1);
    n_cmp++; if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL reset_model got=%h want=%h", dut_vec, exp_vec); end
    n_cmp++; if ({bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_flush} !== 4'b1100) begin
      n_fail++; $display("FAIL reset_ctl got=%b want=1100", {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_flush}); end
    n_cmp++; if ({bus.wb_valid, bus.wb_regwrite, bus.wb_wrreg, bus.stall_cnt, bus.fwd_a, bus.fwd_b} !== '0) begin
      n_fail++; $display("FAIL reset_state wb_valid=%b wb_regwrite=%b wb_wrreg=%0d stall_cnt=%0d want all 0",
                         bus.wb_valid, bus.wb_regwrite, bus.wb_wrreg, bus.stall_cnt); end
    tick();
    drive(NOP, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.pc_en !== 1'b1) begin n_fail++; $display("FAIL reset_idle pc_en got=%b want=1", bus.pc_en); end
    tick();
  endtask

  task automatic test_back_to_back();
    drive(NOP, 1'b0, 1'b0, 1'b1); tick();
    drive(ADD3, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL b2b_c1 got=%h want=%h", dut_vec, exp_vec); end
    tick();
    drive(ADD433, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.pc_en !== FWD_ON) begin n_fail++; $display("FAIL b2b_pc_en got=%b want=%b", bus.pc_en, FWD_ON); end
    tick();
    if (!FWD_ON) begin
      drive(ADD433, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (bus.pc_en !== 1'b0) begin n_fail++; $display("FAIL b2b_stall2 pc_en got=%b want=0", bus.pc_en); end
      tick();
      drive(ADD433, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (bus.pc_en !== 1'b1) begin n_fail++; $display("FAIL b2b_release pc_en got=%b want=1", bus.pc_en); end
      tick();
    end
    drive(NOP, 1'b0, 1'b0, 1'b0);
    n_cmp++; if ({bus.fwd_a, bus.fwd_b} !== (FWD_ON ? 4'b0101 : 4'b0000)) begin
      n_fail++; $display("FAIL b2b_fwd got=%b%b want=%b", bus.fwd_a, bus.fwd_b, FWD_ON ? 4'b0101 : 4'b0000); end
    n_cmp++; if (bus.stall_cnt !== CNT_W'(FWD_ON ? 0 : 2)) begin
      n_fail++; $display("FAIL b2b_cnt got=%0d want=%0d", bus.stall_cnt, FWD_ON ? 0 : 2); end
    n_cmp++; if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL b2b_model got=%h want=%h", dut_vec, exp_vec); end
    tick();
  endtask

  task automatic test_load_use();
    drive(NOP, 1'b0, 1'b0, 1'b1); tick();
    drive(LW5, 1'b0, 1'b0, 1'b0); tick();
    drive(ADD65, 1'b0, 1'b0, 1'b0);
    n_cmp++; if ({bus.pc_en, bus.idex_flush, bus.ifid_flush} !== 3'b010) begin
      n_fail++; $display("FAIL lu_stall pc_en/idex/ifid got=%b want=010", {bus.pc_en, bus.idex_flush, bus.ifid_flush}); end
    tick();
    if (!FWD_ON) begin
      drive(ADD65, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (bus.pc_en !== 1'b0) begin n_fail++; $display("FAIL lu_stall2 pc_en got=%b want=0", bus.pc_en); end
      tick();
    end
    drive(ADD65, 1'b0, 1'b0, 1'b0);
    n_cmp++; if ({bus.pc_en, bus.idex_flush} !== 2'b10) begin
      n_fail++; $display("FAIL lu_once got=%b want=10", {bus.pc_en, bus.idex_flush}); end
    tick();
    drive(NOP, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.fwd_a !== (FWD_ON ? 2'b10 : 2'b00)) begin
      n_fail++; $display("FAIL lu_fwd_a got=%b want=%b", bus.fwd_a, FWD_ON ? 2'b10 : 2'b00); end
    n_cmp++; if (bus.stall_cnt !== CNT_W'(FWD_ON ? 1 : 2)) begin
      n_fail++; $display("FAIL lu_cnt got=%0d want=%0d", bus.stall_cnt, FWD_ON ? 1 : 2); end
    n_cmp++; if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL lu_model got=%h want=%h", dut_vec, exp_vec); end
    tick();
  endtask

  task automatic test_reg_zero();
    drive(NOP, 1'b0, 1'b0, 1'b1); tick();
    drive(W0, 1'b0, 1'b0, 1'b0); tick();
    drive(U0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.pc_en !== 1'b1) begin n_fail++; $display("FAIL r0_nostall pc_en got=%b want=1", bus.pc_en); end
    tick();
    drive(NOP, 1'b0, 1'b0, 1'b0);
    n_cmp++; if ({bus.fwd_a, bus.fwd_b, bus.stall_cnt} !== '0) begin
      n_fail++; $display("FAIL r0_fwd fwd_a=%b fwd_b=%b cnt=%0d want 00 00 0", bus.fwd_a, bus.fwd_b, bus.stall_cnt); end
    tick();
  endtask

  task automatic test_branch();
    drive(NOP, 1'b0, 1'b0, 1'b1); tick();
    drive(LW5, 1'b0, 1'b0, 1'b0); tick();
    drive(ADD65, 1'b1, 1'b0, 1'b0);
    n_cmp++; if ({bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_flush} !== 4'b1111) begin
      n_fail++; $display("FAIL br_flush got=%b want=1111", {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_flush}); end
    tick();
    drive(NOP, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.stall_cnt !== CNT_W'(0)) begin n_fail++; $display("FAIL br_cnt got=%0d want=0", bus.stall_cnt); end
    n_cmp++; if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL br_model got=%h want=%h", dut_vec, exp_vec); end
    tick();
  endtask

  task automatic test_freeze();
    drive(NOP, 1'b0, 1'b0, 1'b1); tick();
    drive(ADD3, 1'b0, 1'b0, 1'b0); tick();
    drive(ADD433, 1'b0, 1'b0, 1'b0); tick();
    for (int c = 0; c < 3; c++) begin
      drive(NOP, 1'b0, 1'b1, 1'b0);
      n_cmp++; if ({bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_flush} !== 4'b0000) begin
        n_fail++; $display("FAIL frz_ctl c=%0d got=%b want=0000", c, {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_flush}); end
      n_cmp++; if (bus.fwd_a !== (FWD_ON ? 2'b01 : 2'b00)) begin
        n_fail++; $display("FAIL frz_fwd c=%0d got=%b want=%b", c, bus.fwd_a, FWD_ON ? 2'b01 : 2'b00); end
      tick();
    end
    drive(NOP, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (bus.stall_cnt !== CNT_W'(FWD_ON ? 3 : 4)) begin
      n_fail++; $display("FAIL frz_cnt got=%0d want=%0d", bus.stall_cnt, FWD_ON ? 3 : 4); end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    model_eval();
    n_cmp++; if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL frz_rst_model got=%h want=%h", dut_vec, exp_vec); end
    n_cmp++; if ({bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_flush, bus.fwd_a, bus.fwd_b, bus.stall_cnt} !== {4'b1100, 4'b0000, CNT_W'(0)}) begin
      n_fail++; $display("FAIL frz_rst_async ctl=%b fwd=%b%b cnt=%0d want 1100 0000 0",
                         {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_flush}, bus.fwd_a, bus.fwd_b, bus.stall_cnt); end
    tick();
    drive(NOP, 1'b0, 1'b0, 1'b0);
    n_cmp++; if ({bus.pc_en, bus.ifid_en, bus.stall_cnt} !== {2'b11, CNT_W'(0)}) begin
      n_fail++; $display("FAIL frz_after pc_en=%b ifid_en=%b cnt=%0d want 1 1 0", bus.pc_en, bus.ifid_en, bus.stall_cnt); end
    tick();
  endtask

  task automatic test_saturate();
    drive(NOP, 1'b0, 1'b0, 1'b1); tick();
    for (int c = 0; c < CNT_MAX + 5; c++) begin
      drive(NOP, 1'b0, 1'b1, 1'b0);
      n_cmp++; if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL sat_model c=%0d got=%h want=%h", c, dut_vec, exp_vec); end
      tick();
    end
    drive(NOP, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.stall_cnt !== CNT_W'(CNT_MAX)) begin
      n_fail++; $display("FAIL sat_cnt got=%0d want=%0d", bus.stall_cnt, CNT_MAX); end
    tick();
  endtask

  task automatic test_random();
    ins_t r;
    drive(NOP, 1'b0, 1'b0, 1'b1); tick();
    for (int c = 0; c < 200; c++) begin
      r = mk($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 1));
      drive(r, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0);
      n_cmp++; if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL rand_model c=%0d got=%h want=%h", c, dut_vec, exp_vec); end
      tick();
    end
  endtask

  initial begin
    NOP    = '0;
    ADD3   = mk(1, 1, 1, 2, 1, 3, 1, 0);
    ADD433 = mk(1, 3, 1, 3, 1, 4, 1, 0);
    LW5    = mk(1, 1, 1, 0, 0, 5, 1, 1);
    ADD65  = mk(1, 5, 1, 0, 1, 6, 1, 0);
    W0     = mk(1, 1, 1, 2, 1, 0, 1, 1);
    U0     = mk(1, 0, 1, 0, 1, 7, 1, 0);
    cur = '0; br = 0; xs = 0;
    model_reset();
    bus.id_valid = 0; bus.id_rs = '0; bus.id_rt = '0; bus.id_use_rs = 0; bus.id_use_rt = 0;
    bus.id_wrreg = '0; bus.id_regwrite = 0; bus.id_memread = 0;
    bus.ex_br_taken = 0; bus.ext_stall = 0;
    test_reset();
    test_back_to_back();
    test_load_use();
    test_reg_zero();
    test_branch();
    test_freeze();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
